// File: rtl/crypto_mix_pipe_if.sv
// Valid/ready bus for the mix pipeline: operand/mode input side and result output side.
interface crypto_mix_pipe_if #(
    parameter int DW = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic [DW-1:0]   in_c;
    logic            in_mode;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_data;

    modport master (
        output in_valid, in_a, in_b, in_c, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/crypto_mix_pipe.sv
// Multiply/accumulate followed by ROUNDS keyed rotate/XOR mixing rounds,
// one register per step, with whole-pipeline backpressure, flush and key load.
module crypto_mix_pipe #(
    parameter int DW     = 32,
    parameter int ROUNDS = 8,
    parameter int ROT    = 2,
    localparam int OW    = 2 * DW,
    localparam int OCC_W = $clog2(ROUNDS + 2)
) (
    input  logic                  clk_buf_0,
    input  logic                  rst_n,
    crypto_mix_pipe_if.slave      bus,
    input  logic                  key_load,
    input  logic [OW-1:0]         key_in,
    output logic                  key_err,
    input  logic                  flush,
    output logic [OCC_W-1:0]      occupancy
);

    function automatic logic [OW-1:0] rotl(input logic [OW-1:0] x);
        return (x << ROT) | (x >> (OW - ROT));
    endfunction

    function automatic logic [OW-1:0] mix_round(input logic [OW-1:0] s, input logic [OW-1:0] k);
        logic [OW-1:0] t;
        t = s + k;
        return rotl(t) ^ s;
    endfunction

    // Stage 0 holds s0; stage ROUNDS is the output register.
    logic [OW-1:0]     data_p [ROUNDS+1];
    logic [ROUNDS:0]   vld_p;
    logic [ROUNDS-1:0] mode_p;
    logic [OW-1:0]     key;
    logic [OW-1:0]     s0;
    logic              adv;
    logic              accept;

    assign adv          = !vld_p[ROUNDS] | bus.out_ready;
    assign bus.in_ready = adv & !flush & rst_n;
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = vld_p[ROUNDS];
    assign bus.out_data  = data_p[ROUNDS];
    assign s0 = {{DW{1'b0}}, bus.in_a} * {{DW{1'b0}}, bus.in_b} + {{DW{1'b0}}, bus.in_c};

    always_comb begin
        occupancy = '0;
        for (int i = 0; i <= ROUNDS; i++) begin
            occupancy = occupancy + OCC_W'(vld_p[i]);
        end
    end

    always_ff @(posedge clk_buf_0 or negedge rst_n) begin
        if (!rst_n) begin
            vld_p   <= '0;
            mode_p  <= '0;
            key     <= '0;
            key_err <= 1'b0;
            for (int i = 0; i <= ROUNDS; i++) begin
                data_p[i] <= '0;
            end
        end else begin
            key_err <= 1'b0;
            if (flush) begin
                vld_p <= '0;
            end else if (adv) begin
                vld_p[0] <= accept;
                for (int i = 1; i <= ROUNDS; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end
            if (adv) begin
                data_p[0] <= s0;
                mode_p[0] <= bus.in_mode;
                for (int i = 1; i < ROUNDS; i++) begin
                    mode_p[i] <= mode_p[i-1];
                end
                // Bypass entries ride the same stages untouched so ordering is preserved.
                for (int i = 1; i <= ROUNDS; i++) begin
                    data_p[i] <= mode_p[i-1] ? data_p[i-1] : mix_round(data_p[i-1], key);
                end
            end
            if (key_load) begin
                if (occupancy == '0 && !accept) begin
                    key <= key_in;
                end else begin
                    key_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crypto_mix_pipe.sv
// Directed bench for crypto_mix_pipe at DW=32, ROUNDS=2, ROT=2 with hand-computed results.
module tb_crypto_mix_pipe;
    localparam int DW = 32;
    localparam int ROUNDS = 2;
    localparam int ROT = 2;

    logic        clk_buf_0 = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_load = 1'b0;
    logic [63:0] key_in = '0;
    logic        key_err;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] got_q[$];
    int occ_peak = 0;

    crypto_mix_pipe_if #(.DW(DW)) bus ();

    crypto_mix_pipe #(.DW(DW), .ROUNDS(ROUNDS), .ROT(ROT)) dut (
        .clk_buf_0 (clk_buf_0),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_err   (key_err),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk_buf_0 = ~clk_buf_0;

    // Inputs only change just after posedge, so the negedge sees what the next edge will see.
    initial begin
        forever begin
            @(negedge clk_buf_0);
            if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic m);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_mode = m;
        @(posedge clk_buf_0); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic m, input logic [63:0] exp);
        int lat;
        lat = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_mode = m;
        do begin
            @(posedge clk_buf_0); #1;
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk({tag, "_data"}, bus.out_data, exp);
        @(posedge clk_buf_0); #1;
    endtask

    task automatic wait_q(input string tag, input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 40) begin
            @(posedge clk_buf_0); #1;
            t++;
        end
        chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
    endtask

    initial begin
        logic [63:0] exp_il [4];
        int idx;
        int cyc;
        logic acc;

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
        bus.in_mode = 1'b0; bus.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_key_err", 64'(key_err), 64'd0);
        @(posedge clk_buf_0); #1;
        rst_n = 1'b1;
        @(posedge clk_buf_0); #1;

        run_one("mix_3_5_1", 32'd3, 32'd5, 32'd1, 1'b0, 64'h110);
        run_one("byp_3_5_1", 32'd3, 32'd5, 32'd1, 1'b1, 64'h10);
        run_one("byp_ovf", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFF00000000);

        // Back-to-back alternating modes.
        got_q.delete();
        exp_il[0] = 64'h110; exp_il[1] = 64'h10; exp_il[2] = 64'h11; exp_il[3] = 64'hA;
        push(32'd3, 32'd5, 32'd1, 1'b0);
        push(32'd3, 32'd5, 32'd1, 1'b1);
        push(32'd1, 32'd1, 32'd0, 1'b0);
        push(32'd2, 32'd3, 32'd4, 1'b1);
        wait_q("il", 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("il_%0d", i), (i < got_q.size()) ? got_q[i] : 64'hDEAD, exp_il[i]);
        end

        // Backpressure: 10 bypass inputs a=i+1, b=2, c=0, downstream stalled for the first 8 cycles.
        @(posedge clk_buf_0); #1;
        got_q.delete(); occ_peak = 0; bus.out_ready = 1'b0; idx = 0; cyc = 0;
        while (idx < 10 && cyc < 100) begin
            bus.in_valid = 1'b1; bus.in_a = 32'(idx + 1); bus.in_b = 32'd2; bus.in_c = 32'd0;
            bus.in_mode = 1'b1;
            @(negedge clk_buf_0);
            acc = bus.in_ready;
            if (cyc == 5) begin
                chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
                chk("bp_out_hold", bus.out_data, 64'd2);
            end
            @(posedge clk_buf_0); #1;
            cyc++;
            if (acc) idx++;
            if (cyc == 8) bus.out_ready = 1'b1;
        end
        bus.in_valid = 1'b0;
        wait_q("bp", 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_%0d", i), (i < got_q.size()) ? got_q[i] : 64'hDEAD, 64'(2 * (i + 1)));
        end
        chk("bp_occ_peak", 64'(occ_peak), 64'd3);

        // Key load while idle, then a rejected load while busy.
        @(posedge clk_buf_0); #1;
        key_load = 1'b1; key_in = 64'd1;
        @(posedge clk_buf_0); #1;
        key_load = 1'b0;
        chk("key_ok_err", 64'(key_err), 64'd0);
        run_one("key1_mix", 32'd3, 32'd5, 32'd1, 1'b0, 64'h100);
        got_q.delete();
        push(32'd3, 32'd5, 32'd1, 1'b0);
        key_load = 1'b1; key_in = 64'd5;
        @(posedge clk_buf_0); #1;
        key_load = 1'b0;
        chk("key_busy_err", 64'(key_err), 64'd1);
        @(posedge clk_buf_0); #1;
        chk("key_err_pulse", 64'(key_err), 64'd0);
        wait_q("key_busy", 1);
        chk("key_busy_data", (got_q.size() > 0) ? got_q[0] : 64'hDEAD, 64'h100);
        run_one("key_kept", 32'd3, 32'd5, 32'd1, 1'b0, 64'h100);

        // Flush with a full, stalled pipeline and a simultaneous input.
        got_q.delete(); bus.out_ready = 1'b0;
        push(32'd3, 32'd5, 32'd1, 1'b0);
        push(32'd4, 32'd5, 32'd1, 1'b0);
        push(32'd5, 32'd5, 32'd1, 1'b0);
        bus.in_valid = 1'b1; flush = 1'b1;
        @(negedge clk_buf_0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
        chk("fl_pre_occ", 64'(occupancy), 64'd3);
        @(posedge clk_buf_0); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        bus.out_ready = 1'b1;
        repeat (4) begin @(posedge clk_buf_0); #1; end
        chk("fl_no_output", 64'(got_q.size()), 64'd0);
        run_one("fl_key_kept", 32'd1, 32'd1, 32'd0, 1'b0, 64'h21);

        // Asynchronous reset mid-stream.
        got_q.delete(); bus.out_ready = 1'b0;
        push(32'd3, 32'd5, 32'd1, 1'b0);
        push(32'd4, 32'd5, 32'd1, 1'b0);
        push(32'd5, 32'd5, 32'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rs_occ", 64'(occupancy), 64'd0);
        chk("rs_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk_buf_0); #1;
        rst_n = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk_buf_0); #1;
        chk("rs_no_output", 64'(got_q.size()), 64'd0);
        run_one("rs_key_zero", 32'd3, 32'd5, 32'd1, 1'b0, 64'h110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
